// File: rtl/fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_if
//   Bundles the instruction-memory port, the ir load port, the decode
//   handshake and the redirect input of fetch_ctrl.
//
//   master (fetch_ctrl side):
//     out mem_read, mem_address[31:0]   word read request / address
//     in  mem_rdata[31:0], mem_resp     read data / single-cycle completion
//     out ir_load, ir_in[31:0]          ir load strobe / data
//     out pc_out[31:0]                  PC of the instruction held in ir
//     out dec_valid / in dec_ready      decode handshake
//     in  redirect, redirect_pc[31:0]   control-flow change pulse / target
//   slave: the same signals with the opposite directions (memory/decode side).
// ---------------------------------------------------------------------------
interface fetch_ctrl_if;
  logic        mem_read;
  logic [31:0] mem_address;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        ir_load;
  logic [31:0] ir_in;
  logic [31:0] pc_out;
  logic        dec_valid;
  logic        dec_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output mem_read, mem_address, ir_load, ir_in, pc_out, dec_valid,
    input  mem_rdata, mem_resp, dec_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_read, mem_address, ir_load, ir_in, pc_out, dec_valid,
    output mem_rdata, mem_resp, dec_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
//   Instruction-fetch sequencer feeding the ir register. Issues word reads,
//   loads returned words into ir, presents them to decode with valid/ready,
//   and handles redirects, including ones that land while a read is in
//   flight (the in-flight read is drained and its data discarded).
//
//   Parameter RESET_PC : fetch address after reset.
//   Ports:
//     clk  : clock, rising-edge
//     rst  : synchronous active-high reset
//     bus  : fetch_ctrl_if.master (memory port, ir port, decode handshake,
//            redirect)
//
//   Build option FETCH_PREFETCH_EN: when defined, adds a one-entry skid
//   buffer so reads continue while ir is held, giving 1 instruction/cycle
//   with zero-wait memory. When undefined fetch is strictly serial.
// ---------------------------------------------------------------------------
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
  input logic          clk,
  input logic          rst,
  fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    START,
    FETCH,
    HOLD,
    DRAIN
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic        dec_valid_q, dec_valid_d;

  logic        rd_active;
  logic [31:0] rd_addr;
  logic        ir_load;
  logic [31:0] ir_in;
  logic [31:0] redir_tgt;
  logic        unused_redir_lsb;

`ifdef FETCH_PREFETCH_EN
  logic [31:0] buf_data_q, buf_data_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        buf_valid_q, buf_valid_d;
`endif

  assign redir_tgt        = {bus.redirect_pc[31:2], 2'b00};
  assign unused_redir_lsb = ^bus.redirect_pc[1:0];

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    dec_valid_d  = dec_valid_q;
    rd_active    = 1'b0;
    rd_addr      = fetch_pc_q;
    ir_load      = 1'b0;
    ir_in        = bus.mem_rdata;
`ifdef FETCH_PREFETCH_EN
    buf_data_d   = buf_data_q;
    buf_pc_d     = buf_pc_q;
    buf_valid_d  = buf_valid_q;
`endif

    unique case (state_q)
      START: begin
        state_d = FETCH;
      end

      FETCH: begin
        rd_active = 1'b1;
        if (bus.redirect) begin
          fetch_pc_d  = redir_tgt;
          dec_valid_d = 1'b0;
`ifdef FETCH_PREFETCH_EN
          buf_valid_d = 1'b0;
`endif
          // A response in the redirect cycle completes the read, so there is
          // nothing left to drain; its data is simply not loaded.
          if (bus.mem_resp) begin
            state_d = FETCH;
          end else begin
            drain_addr_d = fetch_pc_q;
            state_d      = DRAIN;
          end
        end else if (bus.mem_resp) begin
          ir_load     = 1'b1;
          pc_d        = fetch_pc_q;
          fetch_pc_d  = fetch_pc_q + 32'd4;
          dec_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end

      HOLD: begin
`ifdef FETCH_PREFETCH_EN
        // Keep reading ahead while the skid buffer has room; a read is only
        // ever issued with the buffer empty, so a response never finds it full.
        rd_active = !buf_valid_q;
        if (bus.redirect) begin
          fetch_pc_d  = redir_tgt;
          dec_valid_d = 1'b0;
          buf_valid_d = 1'b0;
          if (rd_active && !bus.mem_resp) begin
            drain_addr_d = fetch_pc_q;
            state_d      = DRAIN;
          end else begin
            state_d = FETCH;
          end
        end else if (bus.dec_ready) begin
          if (buf_valid_q) begin
            ir_load     = 1'b1;
            ir_in       = buf_data_q;
            pc_d        = buf_pc_q;
            buf_valid_d = 1'b0;
          end else if (rd_active && bus.mem_resp) begin
            ir_load    = 1'b1;
            pc_d       = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end else begin
            // ir drains with a read still in flight: FETCH keeps the same
            // request asserted at the same address.
            dec_valid_d = 1'b0;
            state_d     = FETCH;
          end
        end else if (rd_active && bus.mem_resp) begin
          buf_data_d  = bus.mem_rdata;
          buf_pc_d    = fetch_pc_q;
          buf_valid_d = 1'b1;
          fetch_pc_d  = fetch_pc_q + 32'd4;
        end
`else
        if (bus.redirect) begin
          fetch_pc_d  = redir_tgt;
          dec_valid_d = 1'b0;
          state_d     = FETCH;
        end else if (bus.dec_ready) begin
          dec_valid_d = 1'b0;
          state_d     = FETCH;
        end
`endif
      end

      DRAIN: begin
        // Old request stays on the bus until memory answers; fetch_pc
        // already holds the redirect target and may be re-targeted again.
        rd_active = 1'b1;
        rd_addr   = drain_addr_q;
        if (bus.redirect) begin
          fetch_pc_d = redir_tgt;
        end
        if (bus.mem_resp) begin
          state_d = FETCH;
        end
      end

      default: begin
        state_d = START;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= START;
      fetch_pc_q   <= RESET_PC;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      dec_valid_q  <= 1'b0;
`ifdef FETCH_PREFETCH_EN
      buf_data_q   <= '0;
      buf_pc_q     <= RESET_PC;
      buf_valid_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      dec_valid_q  <= dec_valid_d;
`ifdef FETCH_PREFETCH_EN
      buf_data_q   <= buf_data_d;
      buf_pc_q     <= buf_pc_d;
      buf_valid_q  <= buf_valid_d;
`endif
    end
  end

  assign bus.mem_read    = rd_active;
  assign bus.mem_address = rd_addr;
  assign bus.ir_load     = ir_load;
  assign bus.ir_in       = ir_in;
  assign bus.pc_out      = pc_q;
  assign bus.dec_valid   = dec_valid_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl
//   Randomized bench for fetch_ctrl. The reference model tracks the
//   instruction stream abstractly: how many fetched words are waiting
//   (in ir plus any skid slot), the PC expected at the head of the stream,
//   the next address that should be requested, and whether the read in
//   flight has been made stale by a redirect. A memory model answers reads
//   with a random or fixed latency and a data word derived from the address.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0060;
`ifdef FETCH_PREFETCH_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_ctrl_if bus ();

  fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // reference model state
  int          q;
  logic [31:0] exp_pc, next_fetch, req_addr, tb_ir;
  bit          out_act, stale, start;
  int          age, lat;

  // stimulus policy
  int          lat_mode;   // 0: random 1..4, else fixed latency
  int          ready_mode; // 0 random, 1 always, 2 pattern 1,0,0,1, 3 one in six
  int          redir_pct;
  int          inj_kind;   // 1: redirect mid-read at inj_at, 2: redirect+ready in hold
  logic [31:0] inj_pc, inj_at;
  int unsigned cyc;

  task automatic model_reset();
    q          = 0;
    exp_pc     = RST_PC;
    next_fetch = RST_PC;
    out_act    = 1'b0;
    stale      = 1'b0;
    start      = 1'b1;
  endtask

  task automatic do_reset();
    bus.redirect  = 1'b0;
    bus.dec_ready = 1'b0;
    bus.mem_resp  = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic one_cycle();
    logic        resp, redir, rdy, acc, hs, exp_irl;
    logic [31:0] tgt;

    check("mem_read", 32'(bus.mem_read), 32'(out_act || (q < CAP && !start)));
    if (start) begin
      check("reset_mem_address", bus.mem_address, RST_PC);
      check("reset_pc_out", bus.pc_out, RST_PC);
    end

    resp = 1'b0;
    if (bus.mem_read) begin
      check("mem_address", bus.mem_address, out_act ? req_addr : next_fetch);
      if (!out_act) begin
        out_act  = 1'b1;
        req_addr = bus.mem_address;
        age      = 0;
        stale    = 1'b0;
        lat      = (lat_mode == 0) ? int'($urandom_range(1, 4)) : lat_mode;
      end
      age++;
      resp = (age >= lat);
    end

    case (ready_mode)
      0:       rdy = 1'($urandom_range(0, 1));
      1:       rdy = 1'b1;
      2:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
      default: rdy = (cyc % 6 == 0);
    endcase
    redir = !start && ($urandom_range(0, 99) < redir_pct);
    tgt   = $urandom;
    if (inj_kind == 1 && bus.mem_read && age == 2 && req_addr == inj_at && !resp) begin
      redir    = 1'b1;
      tgt      = inj_pc;
      inj_kind = 0;
    end else if (inj_kind == 2 && q > 0 && !start) begin
      redir    = 1'b1;
      rdy      = 1'b1;
      tgt      = inj_pc;
      inj_kind = 0;
    end

    bus.mem_resp    = resp;
    bus.mem_rdata   = resp ? memf(req_addr) : $urandom;
    bus.dec_ready   = rdy;
    bus.redirect    = redir;
    bus.redirect_pc = tgt;
    #1;

    hs      = (q > 0) && rdy && !redir;
    acc     = resp && !stale && !redir;
    exp_irl = acc ? ((q == 0) || hs) : (hs && q == 2);

    check("dec_valid", 32'(bus.dec_valid), 32'(q > 0));
    if (q > 0) begin
      check("pc_out", bus.pc_out, exp_pc);
      check("ir_word", tb_ir, memf(exp_pc));
    end
    check("ir_load", 32'(bus.ir_load), 32'(exp_irl));
    if (bus.ir_load) tb_ir = bus.ir_in;

    if (hs) exp_pc = exp_pc + 32'd4;
    if (redir) begin
      if (bus.mem_read && !resp) stale = 1'b1;
      q          = 0;
      next_fetch = {tgt[31:2], 2'b00};
      exp_pc     = next_fetch;
    end else begin
      q = q + (acc ? 1 : 0) - (hs ? 1 : 0);
      if (acc) next_fetch = next_fetch + 32'd4;
    end
    if (resp) out_act = 1'b0;
    start = 1'b0;
    cyc++;

    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) one_cycle();
  endtask

  initial begin
    bus.mem_resp    = 1'b0;
    bus.mem_rdata   = '0;
    bus.dec_ready   = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    tb_ir      = '0;
    cyc        = 0;
    inj_kind   = 0;
    inj_pc     = '0;
    inj_at     = '0;
    age        = 0;
    lat        = 1;
    req_addr   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // zero-wait memory, decode always ready: 0x60, 0x64, 0x68 ...
    lat_mode = 1; ready_mode = 1; redir_pct = 0;
    run(12);

    // 3-cycle reads; redirect to 0x200 one cycle into the read at 0x64
    do_reset();
    lat_mode = 3; inj_kind = 1; inj_at = 32'h64; inj_pc = 32'h200;
    run(30);

    // decode stalls of five cycles in hold
    lat_mode = 1; ready_mode = 3;
    run(30);

    // redirect together with dec_ready in hold, unaligned target 0x103
    ready_mode = 0; inj_kind = 2; inj_pc = 32'h103;
    run(20);

    // ready pattern 1,0,0,1 with zero-wait memory
    ready_mode = 2;
    run(40);

    // address wrap past 0xFFFF_FFFC
    ready_mode = 1; inj_kind = 2; inj_pc = 32'hFFFF_FFF4;
    run(20);

    // random traffic with redirects and resets landing mid-operation
    lat_mode = 0; ready_mode = 0; redir_pct = 8;
    for (int b = 0; b < 4; b++) begin
      run(500 + int'($urandom_range(0, 7)));
      do_reset();
    end
    run(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
